// File: rtl/scan_mux.sv
// Registered CH-channel, W-bit multiplexer with manual select and round-robin auto-scan.
// Define SCAN_MUX_MASK_EN to add a per-channel skip mask (port mask, 1 = skipped).
module scan_mux #(
  parameter int CH    = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [$clog2(CH)-1:0] sel,
  input  logic [CH*W-1:0]       in,
`ifdef SCAN_MUX_MASK_EN
  input  logic [CH-1:0]         mask,
`endif
  output logic [W-1:0]          out,
  output logic [CH-1:0]         dec,
  output logic [$clog2(CH)-1:0] cur,
  output logic                  stb
);
  localparam int SELW = $clog2(CH);
  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [W-1:0]    chans [CH];
  logic [CH-1:0]   skip;
  logic [SELW-1:0] ring_next;
  logic [SELW-1:0] man_cur;
  logic [SELW-1:0] scan_cur;
  logic            enter;
  logic            adv;
  int              idx;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      assign chans[gi] = in[gi*W +: W];
    end
  endgenerate

`ifdef SCAN_MUX_MASK_EN
  assign skip = mask;
`else
  assign skip = '0;
`endif

  // First eligible channel after cur in ascending circular order (cur itself last).
  always_comb begin
    ring_next = cur;
    idx = 0;
    for (int k = CH; k >= 1; k--) begin
      idx = (int'(cur) + k) % CH;
      if (!skip[SELW'(idx)]) ring_next = SELW'(idx);
    end
  end

  assign man_cur  = (int'(sel) < CH) ? sel : cur;
  assign enter    = (state != SCAN);
  // Entry restarts the dwell on cur; a masked cur is left at once.
  assign adv      = skip[cur] || (!enter && cnt == CNT_LAST);
  assign scan_cur = adv ? ring_next : cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
      out   <= '0;
      dec   <= '0;
      stb   <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      out   <= '0;
      dec   <= '0;
      stb   <= 1'b0;
    end else if (!mode) begin
      state <= MANUAL;
      cur   <= man_cur;
      if (skip[man_cur]) begin
        out <= '0;
        dec <= '0;
        stb <= 1'b0;
      end else begin
        out <= chans[man_cur];
        dec <= CH'(1) << man_cur;
        stb <= (man_cur != cur) || (state != MANUAL);
      end
    end else if (&skip) begin
      // Nothing eligible: look idle so scanning restarts cleanly once a channel frees up.
      state <= IDLE;
      cnt   <= '0;
      out   <= '0;
      dec   <= '0;
      stb   <= 1'b0;
    end else begin
      state <= SCAN;
      cur   <= scan_cur;
      cnt   <= (enter || adv) ? '0 : cnt + 1'b1;
      out   <= chans[scan_cur];
      dec   <= CH'(1) << scan_cur;
      stb   <= enter || adv;
    end
  end
endmodule
